// File: rtl/alsu_cmd_driver.sv
// Command-side initiator for the ALSU pin interface: accepts one packed command,
// drives the ALSU pins, waits out the pipeline latency, and returns out/leds with a sequence tag.
module alsu_cmd_driver #(
  parameter int unsigned ALSU_LAT = 2,
  parameter int unsigned SEQ_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [15:0]             cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic signed [5:0]       rsp_out,
  output logic [15:0]             rsp_leds,
  output logic                    rsp_invalid,
  output logic [SEQ_W-1:0]        rsp_seq,
  output logic signed [2:0]       A,
  output logic signed [2:0]       B,
  output logic [2:0]              opcode,
  output logic                    cin,
  output logic                    serial_in,
  output logic                    direction,
  output logic                    red_op_A,
  output logic                    red_op_B,
  output logic                    bypass_A,
  output logic                    bypass_B,
  input  logic signed [5:0]       out,
  input  logic [15:0]             leds
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(ALSU_LAT);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [SEQ_W-1:0] seq;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_seq   = seq;

  // Pins are only written on acceptance, so they hold the last command through WAIT/RESP/IDLE.
  // Capture happens when cnt reaches 0, one edge after the ALSU output register has settled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      seq         <= '0;
      rsp_out     <= '0;
      rsp_leds    <= '0;
      rsp_invalid <= 1'b0;
      A           <= '0;
      B           <= '0;
      opcode      <= '0;
      cin         <= 1'b0;
      serial_in   <= 1'b0;
      direction   <= 1'b0;
      red_op_A    <= 1'b0;
      red_op_B    <= 1'b0;
      bypass_A    <= 1'b0;
      bypass_B    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            {bypass_B, bypass_A, red_op_B, red_op_A,
             direction, serial_in, cin, opcode, B, A} <= cmd_data;
            cnt   <= LAT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_out     <= out;
            rsp_leds    <= leds;
            rsp_invalid <= (leds != '0);
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            seq   <= seq + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Self-checking bench for alsu_cmd_driver with a two-stage behavioural ALSU model
// (input regs + output regs) covering logic, add, multiply, reduction, bypass and invalid cases.
module tb_alsu_cmd_driver;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [15:0]        cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic signed [5:0]  rsp_out;
  logic [15:0]        rsp_leds;
  logic               rsp_invalid;
  logic [7:0]         rsp_seq;
  logic signed [2:0]  A, B;
  logic [2:0]         opcode;
  logic               cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic signed [5:0]  alsu_out;
  logic [15:0]        alsu_leds;

  always #5 clk = ~clk;

  alsu_cmd_driver #(.ALSU_LAT(2), .SEQ_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid), .rsp_seq(rsp_seq),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(alsu_out), .leds(alsu_leds)
  );

  // ALSU model: stage 1 registers the pins, stage 2 computes out/leds.
  logic [2:0]        a_r, b_r, op_r;
  logic              cin_r, ra_r, rb_r, ba_r, bb_r;
  logic signed [5:0] out_m;
  logic [15:0]       leds_m;
  logic              force_en;
  logic signed [5:0] force_val;

  assign alsu_out  = force_en ? force_val : out_m;
  assign alsu_leds = leds_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0; b_r <= '0; op_r <= '0;
      cin_r <= 1'b0; ra_r <= 1'b0; rb_r <= 1'b0; ba_r <= 1'b0; bb_r <= 1'b0;
    end else begin
      a_r <= A; b_r <= B; op_r <= opcode;
      cin_r <= cin; ra_r <= red_op_A; rb_r <= red_op_B; ba_r <= bypass_A; bb_r <= bypass_B;
    end
  end

  logic signed [5:0] sa, sb;
  logic              inval;
  assign sa    = {{3{a_r[2]}}, a_r};
  assign sb    = {{3{b_r[2]}}, b_r};
  assign inval = (op_r > 3'd5) || ((ra_r || rb_r) && (op_r > 3'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_m  <= '0;
      leds_m <= '0;
    end else if (inval) begin
      out_m  <= '0;
      leds_m <= 16'hFFFF;
    end else begin
      leds_m <= '0;
      if (ba_r)      out_m <= sa;
      else if (bb_r) out_m <= sb;
      else begin
        case (op_r)
          3'd0: out_m <= ra_r ? {5'b0, &a_r} : rb_r ? {5'b0, &b_r} : (sa & sb);
          3'd1: out_m <= ra_r ? {5'b0, ^a_r} : rb_r ? {5'b0, ^b_r} : (sa ^ sb);
          3'd2: out_m <= sa + sb + {5'b0, cin_r};
          3'd3: out_m <= sa * sb;
          default: out_m <= '0;
        endcase
      end
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_seq = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pins();
    return {bypass_B, bypass_A, red_op_B, red_op_A, direction, serial_in, cin, opcode, B, A};
  endfunction

  // Accept a command, check pins, latency and response, then consume it with rsp_ready high.
  task automatic do_txn(input logic [15:0] d, input string nm,
                        input logic signed [5:0] eo, input logic ei);
    int n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check({nm, "_ready_timeout"}, 32'(n < 50), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({nm, "_pins"}, {16'd0, pins()}, {16'd0, d});
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({nm, "_latency"}, 32'(n), 32'd3);
    check({nm, "_out"}, {26'd0, rsp_out}, {26'd0, eo});
    check({nm, "_invalid"}, {31'd0, rsp_invalid}, {31'd0, ei});
    check({nm, "_leds_nz"}, {31'd0, rsp_leds != 16'd0}, {31'd0, ei});
    check({nm, "_seq"}, {24'd0, rsp_seq}, {24'd0, exp_seq});
    @(posedge clk); #1;
    check({nm, "_consumed"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    exp_seq++;
  endtask

  typedef struct {
    logic [15:0]       data;
    logic signed [5:0] exp_out;
    logic              exp_inv;
    string             name;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic signed [5:0] s_out;
    logic [15:0]       s_leds;
    logic              s_inv;
    logic [7:0]        s_seq;
    int                seen;

    // {B[5:3], A[2:0]}, opcode [8:6], cin [9], red_op_A [12], bypass_A [14]
    vt[0] = '{16'd147,   6'sd5,   1'b0, "add"};      // 3+2
    vt[1] = '{16'd220,  -6'sd12,  1'b0, "mul"};      // -4*3
    vt[2] = '{16'd393,   6'sd0,   1'b1, "op6"};      // invalid opcode
    vt[3] = '{16'd29,    6'sd1,   1'b0, "and"};      // 101 & 011
    vt[4] = '{16'd93,   -6'sd2,   1'b0, "xor"};      // 101 ^ 011
    vt[5] = '{16'd695,  -6'sd2,   1'b0, "addc"};     // -1 + -2 + 1
    vt[6] = '{16'd4103,  6'sd1,   1'b0, "redand"};   // &A, A=7
    vt[7] = '{16'd4231,  6'sd0,   1'b1, "redadd"};   // red_op with add
    vt[8] = '{16'd16587, 6'sd3,   1'b0, "bypA"};     // bypass_A, A=3

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b1;
    force_en = 1'b0; force_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp", {rsp_valid, rsp_invalid, rsp_out, rsp_leds, rsp_seq}, 32'd0);
    check("rst_pins", {16'd0, pins()}, 32'd0);

    foreach (vt[i]) do_txn(vt[i].data, vt[i].name, vt[i].exp_out, vt[i].exp_inv);

    // Backpressure: response held while out toggles and cmd_valid is asserted.
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 16'd220;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen = 0;
    while (!rsp_valid && seen < 50) begin @(posedge clk); #1; seen++; end
    check("bp_latency", 32'(seen), 32'd3);
    s_out = rsp_out; s_leds = rsp_leds; s_inv = rsp_invalid; s_seq = rsp_seq;
    check("bp_out", {26'd0, s_out}, {26'd0, -6'sd12});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      force_en = 1'b1; force_val = 6'(i * 7 + 3);
      cmd_valid = 1'b1; cmd_data = 16'd393;
      @(posedge clk); #1;
      check("bp_stable", {rsp_valid, rsp_invalid, rsp_out, rsp_leds, rsp_seq},
            {1'b1, s_inv, s_out, s_leds, s_seq});
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_pins_hold", {16'd0, pins()}, 32'd220);
    end
    @(negedge clk);
    cmd_valid = 1'b0; force_en = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    exp_seq++;

    // Reset together with cmd_valid: command must not be accepted.
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1; cmd_data = 16'd147;
    @(posedge clk); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    exp_seq = '0;
    @(posedge clk); #1;
    check("rst_cmd_pins", {16'd0, pins()}, 32'd0);
    check("rst_cmd_ready", {30'd0, rsp_valid, cmd_ready}, 32'b01);

    // Reset one cycle after accept: in-flight command dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 16'd147;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midwait_pins", {16'd0, pins()}, 32'd0);
    check("midwait_rsp", {rsp_valid, rsp_invalid, rsp_out, rsp_leds, rsp_seq}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("midwait_no_rsp", 32'(seen), 32'd0);
    do_txn(16'd147, "post_rst_add", 6'sd5, 1'b0);

    // Sequence wrap from a fresh reset: 257 transactions, last one tagged 0.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_seq = '0;
    for (int i = 0; i < 257; i++) begin
      if (i == 256) check("wrap_expect_zero", {24'd0, exp_seq}, 32'd0);
      do_txn(16'd147, "wrap", 6'sd5, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
